// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared state, branch, cause and vector constants for the PC/exception stage
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SAVE = 2'd1,
        WAIT = 2'd2,
        LOAD = 2'd3
    } exc_state_t;

    localparam logic [1:0] BR_BEQ = 2'b00;
    localparam logic [1:0] BR_BNE = 2'b01;
    localparam logic [1:0] BR_BGT = 2'b10;
    localparam logic [1:0] BR_BLE = 2'b11;

    localparam logic [1:0] CAUSE_NONE   = 2'b00;
    localparam logic [1:0] CAUSE_OPCODE = 2'b01;
    localparam logic [1:0] CAUSE_OVF    = 2'b10;
    localparam logic [1:0] CAUSE_DIV0   = 2'b11;

    localparam logic [31:0] DEF_VEC_OPCODE = 32'd253;
    localparam logic [31:0] DEF_VEC_OVF    = 32'd254;
    localparam logic [31:0] DEF_VEC_DIV0   = 32'd255;

    // Priority encode simultaneous exception pulses: opcode > overflow > div0.
    function automatic logic [1:0] exc_cause_of(input logic opcode, input logic overflow,
                                                input logic div0);
        if (opcode)
            return CAUSE_OPCODE;
        else if (overflow)
            return CAUSE_OVF;
        else if (div0)
            return CAUSE_DIV0;
        else
            return CAUSE_NONE;
    endfunction

endpackage

// File: rtl/branch_cond.sv
// rtl/branch_cond.sv - combinational branch condition from branch_type and ALU flags
module branch_cond
    import cpu_pkg::*;
(
    input  logic [1:0] branch_type,
    input  logic       alu_zero,
    input  logic       alu_gt,
    output logic       cond
);

    always_comb begin
        cond = 1'b0;
        case (branch_type)
            BR_BEQ:  cond = alu_zero;
            BR_BNE:  cond = !alu_zero;
            BR_BGT:  cond = alu_gt;
            BR_BLE:  cond = !alu_gt;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_exception_unit.sv
// rtl/pc_exception_unit.sv - PC/EPC registers and exception entry sequencer; optional EXC_CAUSE_EN adds exc_cause
module pc_exception_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          MEM_LAT    = 1,
    parameter logic [31:0] VEC_OPCODE = DEF_VEC_OPCODE,
    parameter logic [31:0] VEC_OVF    = DEF_VEC_OVF,
    parameter logic [31:0] VEC_DIV0   = DEF_VEC_DIV0
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_next,
    input  logic        pc_write,
    input  logic        pc_write_cond,
    input  logic [1:0]  branch_type,
    input  logic        alu_zero,
    input  logic        alu_gt,
    input  logic        exc_opcode,
    input  logic        exc_overflow,
    input  logic        exc_div0,
    input  logic [7:0]  mem_byte,
    output logic [31:0] pc,
    output logic [31:0] epc,
    output logic        exc_busy,
    output logic        exc_mem_req,
    output logic [31:0] exc_mem_addr
`ifdef EXC_CAUSE_EN
    ,
    output logic [1:0]  exc_cause
`endif
);

    exc_state_t  state;
    exc_state_t  state_next;
    logic [3:0]  wait_cnt;
    logic        cond;
    logic        exc_any;
    logic [1:0]  cause_now;
    logic [31:0] vec_now;

    branch_cond u_branch_cond (
        .branch_type (branch_type),
        .alu_zero    (alu_zero),
        .alu_gt      (alu_gt),
        .cond        (cond)
    );

    assign exc_any   = exc_opcode | exc_overflow | exc_div0;
    assign cause_now = exc_cause_of(exc_opcode, exc_overflow, exc_div0);
    assign exc_busy  = (state != IDLE);

    always_comb begin
        vec_now = VEC_DIV0;
        case (cause_now)
            CAUSE_OPCODE: vec_now = VEC_OPCODE;
            CAUSE_OVF:    vec_now = VEC_OVF;
            default:      vec_now = VEC_DIV0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (exc_any) state_next = SAVE;
            SAVE:    state_next = WAIT;
            WAIT:    if (wait_cnt == 4'd1) state_next = LOAD;
            LOAD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Request/address are set on the IDLE->SAVE edge so they read as Moore outputs of SAVE/WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc           <= RESET_PC;
            epc          <= 32'd0;
            wait_cnt     <= 4'd0;
            exc_mem_req  <= 1'b0;
            exc_mem_addr <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (exc_any) begin
                        exc_mem_req  <= 1'b1;
                        exc_mem_addr <= vec_now;
                    end else if (pc_write | (pc_write_cond & cond)) begin
                        pc <= pc_next;
                    end
                end
                SAVE: begin
                    epc      <= pc - 32'd4;
                    wait_cnt <= 4'(MEM_LAT);
                end
                WAIT: begin
                    if (wait_cnt == 4'd1) begin
                        wait_cnt    <= 4'd0;
                        exc_mem_req <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                LOAD: begin
                    pc <= {24'b0, mem_byte};
                end
                default: begin
                end
            endcase
        end
    end

`ifdef EXC_CAUSE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            exc_cause <= CAUSE_NONE;
        else if (state == IDLE && exc_any)
            exc_cause <= cause_now;
    end
`endif

endmodule
